// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle: raw active-low buttons in, press strobes and
// debounced levels out.
interface btn_conditioner_if #(
   parameter int N_BTN = 3
);
   logic [N_BTN-1:0] btn_b;
   logic [N_BTN-1:0] pulse;
   logic [N_BTN-1:0] level;

   modport master (output btn_b, input pulse, input level);
   modport slave  (input btn_b, output pulse, output level);
endinterface

// File: rtl/btn_conditioner.sv
// Per-channel 2-flop synchronizer plus a debounce FSM.
// Each channel emits a one-clock press strobe and a debounced pressed level.
module btn_conditioner #(
   parameter int N_BTN     = 3,
   parameter int DB_CYCLES = 500000,
   parameter int CNT_W     = 20
) (
   input  logic             clk,
   input  logic             reset_b,
   btn_conditioner_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   state_t           state [N_BTN];
   logic [CNT_W-1:0] cnt   [N_BTN];
   logic [N_BTN-1:0] sync1, sync2, pulse_r, level_r;
   logic [N_BTN-1:0] s;

   // Synchronizer flops hold the raw (active-low) value, so reset leaves them released.
   assign s         = ~sync2;
   assign bus.pulse = pulse_r;
   assign bus.level = level_r;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         sync1   <= '1;
         sync2   <= '1;
         pulse_r <= '0;
         level_r <= '0;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
         end
      end else begin
         sync1   <= bus.btn_b;
         sync2   <= sync1;
         pulse_r <= '0;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            case (state[i])
               IDLE: begin
                  if (s[i]) begin
                     state[i] <= PRESS_WAIT;
                     cnt[i]   <= '0;
                  end
               end
               PRESS_WAIT: begin
                  if (!s[i]) begin
                     state[i] <= IDLE;
                  end else if (cnt[i] >= CNT_LAST) begin
                     state[i]   <= PRESSED;
                     pulse_r[i] <= 1'b1;
                     level_r[i] <= 1'b1;
                  end else begin
                     cnt[i] <= cnt[i] + CNT_W'(1);
                  end
               end
               PRESSED: begin
                  if (!s[i]) begin
                     state[i] <= RELEASE_WAIT;
                     cnt[i]   <= '0;
                  end
               end
               RELEASE_WAIT: begin
                  if (s[i]) begin
                     state[i] <= PRESSED;
                  end else if (cnt[i] >= CNT_LAST) begin
                     state[i]   <= IDLE;
                     level_r[i] <= 1'b0;
                  end else begin
                     cnt[i] <= cnt[i] + CNT_W'(1);
                  end
               end
               default: state[i] <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bouncing, checked every
// cycle against a run-length debounce model.
module tb_btn_conditioner;

   localparam int N  = 3;
   localparam int DB = 4;
   localparam int CW = 20;

   logic         clk = 1'b0;
   logic         reset_b;
   logic [N-1:0] btn;

   always #5 clk = ~clk;

   btn_conditioner_if #(.N_BTN(N)) bus ();
   assign bus.btn_b = btn;

   btn_conditioner #(.N_BTN(N), .DB_CYCLES(DB), .CNT_W(CW)) dut (
      .clk     (clk),
      .reset_b (reset_b),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;

   // Model: a level flips once DB+1 consecutive post-sync samples disagree with it.
   logic [N-1:0] m_d1, m_d2, m_lvl, m_pulse;
   int           m_run [N];

   // Statistics taken from observed DUT outputs
   int           pcnt  [N];
   int           plast [N];
   int           lfall [N];
   int           lhi   [N];
   logic [N-1:0] lvl_seen, prev_lvl;

   task automatic model_reset();
      m_d1    = '1;
      m_d2    = '1;
      m_lvl   = '0;
      m_pulse = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
   endtask

   task automatic clr();
      for (int i = 0; i < N; i++) begin
         pcnt[i]  = 0;
         plast[i] = -1;
         lfall[i] = -1;
         lhi[i]   = 0;
      end
      lvl_seen = '0;
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      logic s;
      @(posedge clk);
      edge_n++;
      if (!reset_b) begin
         model_reset();
      end else begin
         for (int i = 0; i < N; i++) begin
            s          = ~m_d2[i];
            m_pulse[i] = 1'b0;
            if (s != m_lvl[i]) m_run[i]++;
            else               m_run[i] = 0;
            if (m_run[i] == DB + 1) begin
               m_lvl[i]   = s;
               m_pulse[i] = s;
               m_run[i]   = 0;
            end
         end
         m_d2 = m_d1;
         m_d1 = btn;
      end
      #1;
      checks++;
      assert (bus.pulse === m_pulse) else begin
         failures++;
         $error("FAIL pulse edge=%0d got=%b expected=%b", edge_n, bus.pulse, m_pulse);
      end
      checks++;
      assert (bus.level === m_lvl) else begin
         failures++;
         $error("FAIL level edge=%0d got=%b expected=%b", edge_n, bus.level, m_lvl);
      end
      for (int i = 0; i < N; i++) begin
         if (bus.pulse[i] === 1'b1) begin
            pcnt[i]++;
            plast[i] = edge_n;
         end
         if (bus.level[i] === 1'b1) begin
            lvl_seen[i] = 1'b1;
            lhi[i]++;
         end
         if (prev_lvl[i] === 1'b1 && bus.level[i] === 1'b0) lfall[i] = edge_n;
      end
      prev_lvl = bus.level;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   initial begin
      int k;
      int r;

      reset_b  = 1'b0;
      btn      = '1;
      prev_lvl = '0;
      model_reset();
      clr();
      #1;
      chk("reset_pulse", int'(bus.pulse), 0);
      chk("reset_level", int'(bus.level), 0);
      ticks(3);
      reset_b = 1'b1;
      ticks(4);

      // Clean hold on channel 0
      clr();
      btn[0] = 1'b0;
      k = edge_n + 1;
      ticks(50);
      btn[0] = 1'b1;
      ticks(12);
      chk("hold_pcnt0", pcnt[0], 1);
      chk("hold_pedge0", plast[0], k + 2 + DB);
      chk("hold_other", pcnt[1] + pcnt[2], 0);
      chk("hold_lvl_end", int'(bus.level[0]), 0);

      // Short bounces on channel 1 never qualify
      clr();
      btn[1] = 1'b0; ticks(3);
      btn[1] = 1'b1; ticks(1);
      btn[1] = 1'b0; ticks(2);
      btn[1] = 1'b1; ticks(10);
      chk("bounce_pcnt1", pcnt[1], 0);
      chk("bounce_lvl1", int'(lvl_seen[1]), 0);

      // Clean press, bouncy release on channel 2
      clr();
      btn[2] = 1'b0; ticks(10);
      btn[2] = 1'b1; ticks(2);
      btn[2] = 1'b0; ticks(2);
      btn[2] = 1'b1; ticks(2);
      btn[2] = 1'b0; ticks(2);
      btn[2] = 1'b1;
      r = edge_n + 1;
      ticks(12);
      chk("relb_pcnt2", pcnt[2], 1);
      chk("relb_fall2", lfall[2], r + 2 + DB);

      // Simultaneous press
      clr();
      btn = '0;
      k = edge_n + 1;
      ticks(10);
      for (int i = 0; i < N; i++) begin
         chk("simul_pcnt", pcnt[i], 1);
         chk("simul_pedge", plast[i], k + 2 + DB);
      end
      btn = '1;
      ticks(10);

      // Reset in the middle of PRESS_WAIT with the button held
      clr();
      btn[0] = 1'b0;
      ticks(5);
      reset_b = 1'b0;
      #1;
      chk("midrst_pulse", int'(bus.pulse), 0);
      chk("midrst_level", int'(bus.level), 0);
      ticks(2);
      chk("midrst_nopulse", pcnt[0], 0);
      reset_b = 1'b1;
      r = edge_n + 1;
      ticks(12);
      chk("midrst_pcnt", pcnt[0], 1);
      chk("midrst_pedge", plast[0], r + 2 + DB);
      btn[0] = 1'b1;
      ticks(10);

      // Long hold: one pulse, level never drops
      clr();
      btn[0] = 1'b0;
      ticks(10000);
      chk("long_pcnt", pcnt[0], 1);
      chk("long_lhi", lhi[0], 10000 - (2 + DB));
      btn[0] = 1'b1;
      ticks(10);

      // Random bouncing with occasional resets
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(5) == 0) btn[i] = ~btn[i];
         if ($urandom_range(399) == 0) begin
            reset_b = 1'b0;
            ticks(int'($urandom_range(3, 1)));
            reset_b = 1'b1;
         end
         tick();
      end
      btn = '1;
      ticks(12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
